// File: rtl/div_issue_sequencer_pkg.sv
// Shared fixed-point constants and FSM encoding for the divider issue/collect stage.
// Q-format words: bits [N-1:SF_W] signed mantissa, [SF_W-1:0] scale factor.
package div_issue_sequencer_pkg;

    localparam int N      = 16;
    localparam int SF_W   = 3;
    localparam int OUT_SF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    // Largest positive / most negative mantissa, tagged with the divider's output scale.
    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-SF_W-1){1'b1}}, SF_W'(OUT_SF)};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-SF_W-1){1'b0}}, SF_W'(OUT_SF)};

    function automatic logic [N-1:0] sat_word(input logic sign);
        return sign ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/div_issue_sequencer_if.sv
// Bundle of upstream request, divider-side and downstream result signals.
// master = the sequencer, slave = everything around it (source, divider, sink).
interface div_issue_sequencer_if;
    import div_issue_sequencer_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_dividend;
    logic [N-1:0] in_divisor;

    logic         div_load;
    logic [N-1:0] div_dividend;
    logic [N-1:0] div_divisor;
    logic [N-1:0] div_q;
    logic         div_ready;
    logic         div_overflow;
    logic         div_dbz;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_q;
    logic         out_overflow;
    logic         out_dbz;
    logic         out_timeout;

    modport master (
        input  in_valid, in_dividend, in_divisor,
        output in_ready,
        output div_load, div_dividend, div_divisor,
        input  div_q, div_ready, div_overflow, div_dbz,
        output out_valid, out_q, out_overflow, out_dbz, out_timeout,
        input  out_ready
    );

    modport slave (
        output in_valid, in_dividend, in_divisor,
        input  in_ready,
        input  div_load, div_dividend, div_divisor,
        output div_q, div_ready, div_overflow, div_dbz,
        input  out_valid, out_q, out_overflow, out_dbz, out_timeout,
        output out_ready
    );

endinterface

// File: rtl/div_issue_sequencer.sv
// Issue/collect sequencer for the Q-format divider: one request in flight, timeout guarded.
// Optional DIV_SAT_EN: saturate out_q on overflow / divide-by-zero.
module div_issue_sequencer
    import div_issue_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 32,
    parameter int TW      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    div_issue_sequencer_if.master bus
);

    seq_state_e   state_q;
    logic         in_ready_q;
    logic         div_load_q;
    logic [N-1:0] dividend_q;
    logic [N-1:0] divisor_q;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic         timer_expired;
    logic         out_valid_q;
    logic [N-1:0] out_q_q;
    logic         out_overflow_q;
    logic         out_dbz_q;
    logic         out_timeout_q;
    logic [N-1:0] capture_q_d;

    assign timer_d       = timer_q + TW'(1);
    assign timer_expired = (timer_q == TW'(TIMEOUT - 1));

`ifdef DIV_SAT_EN
    logic sign_q;

    assign capture_q_d = (bus.div_dbz || bus.div_overflow) ? sat_word(sign_q) : bus.div_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q <= 1'b0;
        end else if (state_q == IDLE && bus.in_valid && in_ready_q) begin
            sign_q <= bus.in_dividend[N-1] ^ bus.in_divisor[N-1];
        end
    end
`else
    assign capture_q_d = bus.div_q;
`endif

    // Reset leaves div_load high so the divider stays reinitialised until the first edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            in_ready_q     <= 1'b0;
            div_load_q     <= 1'b1;
            dividend_q     <= '0;
            divisor_q      <= '0;
            timer_q        <= '0;
            out_valid_q    <= 1'b0;
            out_q_q        <= '0;
            out_overflow_q <= 1'b0;
            out_dbz_q      <= 1'b0;
            out_timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    div_load_q <= 1'b0;
                    if (bus.in_valid && in_ready_q) begin
                        dividend_q <= bus.in_dividend;
                        divisor_q  <= bus.in_divisor;
                        in_ready_q <= 1'b0;
                        div_load_q <= 1'b1;
                        state_q    <= LOAD;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    div_load_q <= 1'b0;
                    timer_q    <= '0;
                    state_q    <= RUN;
                end
                RUN: begin
                    if (bus.div_ready) begin
                        out_q_q        <= capture_q_d;
                        out_dbz_q      <= bus.div_dbz;
                        out_overflow_q <= bus.div_overflow & ~bus.div_dbz;
                        out_timeout_q  <= 1'b0;
                        out_valid_q    <= 1'b1;
                        state_q        <= DONE;
                    end else if (timer_expired) begin
                        out_q_q        <= '0;
                        out_dbz_q      <= 1'b0;
                        out_overflow_q <= 1'b0;
                        out_timeout_q  <= 1'b1;
                        out_valid_q    <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                DONE: begin
                    // Handshake edge returns to IDLE with in_ready already set for the next cycle.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.div_load     = div_load_q;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_q        = out_q_q;
    assign bus.out_overflow = out_overflow_q;
    assign bus.out_dbz      = out_dbz_q;
    assign bus.out_timeout  = out_timeout_q;

endmodule

// File: tb/tb_div_issue_sequencer.sv
// Bench for div_issue_sequencer: divider stub, cycle-level transaction model, directed requests.
module tb_div_issue_sequencer;

    localparam int TIMEOUT = 32;
    localparam int NEVER   = 1 << 30;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    div_issue_sequencer_if bus ();

    div_issue_sequencer #(.TIMEOUT(TIMEOUT), .TW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Request staged by the driver, promoted to "current" when the model sees it accepted.
    logic [15:0] pend_dd, pend_dv, pend_q;
    int          pend_k;
    bit          pend_never, pend_ovf, pend_dbz;
    logic [15:0] cur_dd = '0, cur_dv = '0, cur_q = '0;
    int          cur_k = 0;
    bit          cur_never = 1'b1, cur_ovf = 1'b0, cur_dbz = 1'b0;

    int acc_cyc  = -1;
    int hs_cyc   = NEVER;
    int last_rst = 0;
    int run_len  = 0;
    logic [15:0] exp_q;
    bit          exp_ovf, exp_dbz, exp_tmo;

    // Divider stub: held in reset by div_load, reports done cur_k cycles after release.
    int scnt = 0;
    always @(posedge clk) begin
        if (bus.div_load) scnt <= 0;
        else if (scnt < 100000) scnt <= scnt + 1;
    end
    assign bus.div_ready    = !cur_never && (scnt >= cur_k);
    assign bus.div_q        = cur_q;
    assign bus.div_overflow = cur_ovf;
    assign bus.div_dbz      = cur_dbz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic void expect_result();
        if (cur_never) begin
            exp_q = 16'h0000; exp_ovf = 0; exp_dbz = 0; exp_tmo = 1;
        end else begin
            exp_dbz = cur_dbz;
            exp_ovf = cur_ovf && !cur_dbz;
            exp_tmo = 0;
            exp_q   = cur_q;
`ifdef DIV_SAT_EN
            if (exp_dbz || exp_ovf)
                exp_q = (cur_dd[15] ^ cur_dv[15]) ? 16'h8003 : 16'h7FFB;
`endif
        end
    endfunction

    // Model: accept edge a -> div_load during cycle a, result after one LOAD and run_len RUN cycles.
    always @(negedge clk) begin
        bit post, busy, ov;
        if (reset) begin
            last_rst = cyc;
            acc_cyc  = -1;
            hs_cyc   = NEVER;
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
            chk("rst_div_load", 32'(bus.div_load), 32'd1);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_word", {13'd0, bus.out_overflow, bus.out_dbz, bus.out_timeout, bus.out_q}, 32'd0);
        end else begin
            post = (cyc >= last_rst + 2);
            busy = (acc_cyc >= 0) && (cyc >= acc_cyc) && (cyc < hs_cyc);
            ov   = busy && (cyc >= acc_cyc + 1 + run_len);
            chk("in_ready", 32'(bus.in_ready), 32'(post && !busy));
            chk("div_load", 32'(bus.div_load), 32'(!post || cyc == acc_cyc));
            chk("out_valid", 32'(bus.out_valid), 32'(ov));
            if (busy) begin
                chk("div_dividend", 32'(bus.div_dividend), 32'(cur_dd));
                chk("div_divisor", 32'(bus.div_divisor), 32'(cur_dv));
            end
            if (ov) begin
                chk("out_q", 32'(bus.out_q), 32'(exp_q));
                chk("out_flags", {29'd0, bus.out_overflow, bus.out_dbz, bus.out_timeout},
                    {29'd0, exp_ovf, exp_dbz, exp_tmo});
                if (bus.out_ready) hs_cyc = cyc + 1;
            end
            if (post && !busy && bus.in_valid) begin
                acc_cyc   = cyc + 1;
                hs_cyc    = NEVER;
                cur_dd    = pend_dd;   cur_dv  = pend_dv;   cur_q   = pend_q;
                cur_k     = pend_k;    cur_never = pend_never;
                cur_ovf   = pend_ovf;  cur_dbz = pend_dbz;
                run_len   = cur_never ? TIMEOUT : cur_k + 1;
                expect_result();
            end
        end
    end

    // Called at posedge+1; returns at the negedge out_valid is first seen (or right after accept).
    task automatic issue(input logic [15:0] dd, input logic [15:0] dv, input int k, input bit never,
                         input logic [15:0] q, input bit ovf, input bit dbz, input bit wait_out,
                         output int lat);
        bit got = 0;
        pend_dd = dd; pend_dv = dv; pend_q = q; pend_k = k;
        pend_never = never; pend_ovf = ovf; pend_dbz = dbz;
        bus.in_dividend = dd;
        bus.in_divisor  = dv;
        bus.in_valid    = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (acc_cyc == cyc) begin got = 1; break; end
        end
        chk("accepted", 32'(got), 32'd1);
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.in_dividend = ~dd;
        bus.in_divisor  = ~dv;
        lat = -1;
        if (wait_out && got) begin
            for (int n = 0; n < 80; n++) begin
                @(negedge clk);
                if (bus.out_valid) begin lat = cyc - acc_cyc; break; end
            end
            chk("out_valid_seen", 32'(lat >= 0), 32'd1);
        end
        $display("req dd=%h dv=%h k=%0d never=%0d acc=%0d latency=%0d", dd, dv, k, never, acc_cyc, lat);
    endtask

    task automatic drain(input int hold, input bit poke);
        bit done = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (poke) bus.in_valid = (i % 3 == 1);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            if (hs_cyc == cyc) begin done = 1; break; end
        end
        bus.out_ready = 1'b0;
        chk("handshake", 32'(done), 32'd1);
        $display("drain hold=%0d handshake_cyc=%0d", hold, hs_cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.in_valid = 0; bus.in_dividend = '0; bus.in_divisor = '0; bus.out_ready = 0;
        pend_dd = '0; pend_dv = '0; pend_q = '0; pend_k = 0;
        pend_never = 1; pend_ovf = 0; pend_dbz = 0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // 1: nominal divide
        issue(16'h0030, 16'h0010, 17, 0, 16'h00C3, 0, 0, 1, lat);
        chk("t1_latency", 32'(lat), 32'd19);
        chk("t1_q", 32'(bus.out_q), 32'h00C3);
        chk("t1_flags", {29'd0, bus.out_overflow, bus.out_dbz, bus.out_timeout}, 32'd0);
        drain(0, 0);

        // 2: downstream stall with illegal in_valid pokes
        issue(16'h0100, 16'h0020, 5, 0, 16'h0043, 0, 0, 1, lat);
        chk("t2_latency", 32'(lat), 32'd7);
        drain(10, 1);
        @(negedge clk);
        chk("t2_idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // 3: overflow, negative quotient sign
        issue(16'h8000, 16'h0008, 17, 0, 16'h0000, 1, 0, 1, lat);
`ifdef DIV_SAT_EN
        chk("t3_q", 32'(bus.out_q), 32'h8003);
`else
        chk("t3_q", 32'(bus.out_q), 32'h0000);
`endif
        chk("t3_overflow", 32'(bus.out_overflow), 32'd1);
        drain(0, 0);

        // 4: divide by zero wins over overflow
        issue(16'h0040, 16'h0000, 17, 0, 16'h0000, 1, 1, 1, lat);
        chk("t4_flags", {29'd0, bus.out_overflow, bus.out_dbz, bus.out_timeout}, 32'd2);
`ifdef DIV_SAT_EN
        chk("t4_q", 32'(bus.out_q), 32'h7FFB);
`else
        chk("t4_q", 32'(bus.out_q), 32'h0000);
`endif
        drain(0, 0);

        // 5: hung divider, then back-to-back request during the result handshake
        issue(16'h0123, 16'h0045, 17, 1, 16'h1234, 0, 0, 1, lat);
        chk("t5_latency", 32'(lat), 32'd33);
        chk("t5_timeout", 32'(bus.out_timeout), 32'd1);
        chk("t5_q", 32'(bus.out_q), 32'h0000);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        issue(16'hFFF0, 16'h0010, 3, 0, 16'hFFF3, 0, 0, 1, lat);
        chk("b2b_latency", 32'(lat), 32'd5);
        drain(0, 0);

        // 6: reset during RUN cycle 5, then a clean request
        issue(16'h0200, 16'h0010, 17, 0, 16'h0111, 0, 0, 0, lat);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t6_load_async", 32'(bus.div_load), 32'd1);
        chk("t6_no_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        issue(16'h0300, 16'h0010, 4, 0, 16'h0022, 0, 0, 1, lat);
        chk("t6_latency", 32'(lat), 32'd6);
        chk("t6_q", 32'(bus.out_q), 32'h0022);
        drain(0, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
